mvu_weight_sequencer: RTL and testbench

//  Weight-stream controller for the MVU/VVU AXI core. Reads a weight memory of NF*SF words
//  (word = PE*SIMD weights) in MVU order and emits it on an AXI-stream feeding the core's

---
 rtl/mvu_weight_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mvu_weight_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_weight_sequencer.sv
// Weight-stream controller: replays an NF*SF-word weight memory in MVU order once per
// input vector, prefetching reads under a credit limit into a small registered-output FIFO.
module mvu_weight_sequencer #(
  parameter int MW           = 8,
  parameter int MH           = 4,
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int WEIGHT_WIDTH = 3,
  parameter int MEM_LAT      = 2,
  localparam int SF          = MW / SIMD,
  localparam int NF          = MH / PE,
  localparam int WORDS       = NF * SF,
  localparam int AW          = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int WW          = PE * SIMD * WEIGHT_WIDTH,
  localparam int WW_BA       = (WW + 7) / 8 * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       num_vectors,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [WW-1:0]     mem_rdata,
  output logic [WW_BA-1:0]  m_axis_weights_tdata,
  output logic              m_axis_weights_tvalid,
  input  logic              m_axis_weights_tready,
  output logic              m_axis_weights_tlast
);

  localparam int DEPTH = MEM_LAT + 2;
  localparam int BUF_N = DEPTH - 1;
  localparam int PW    = $clog2(BUF_N);
  localparam int CW    = $clog2(BUF_N + 1);
  localparam int OW    = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(BUF_N - 1);
  localparam logic [OW-1:0] CREDITS   = OW'(DEPTH);
  localparam logic [CW-1:0] BUF_FULL  = CW'(BUF_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     nv_q, nv_d;
  logic [31:0]     vec_q, vec_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [OW-1:0]   outs_q, outs_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] lst_q, lst_d;

  logic [WW-1:0]   buf_q [BUF_N];
  logic [WW-1:0]   buf_d [BUF_N];
  logic            blst_q [BUF_N];
  logic            blst_d [BUF_N];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WW-1:0]   tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;

  logic            hs;
  logic            issue;
  logic            addr_last;
  logic            run_last;
  logic            push;
  logic            out_free;
  logic            buf_pull;
  logic            buf_push;

  assign hs        = tvalid_q && m_axis_weights_tready;
  // A full credit pool may still issue when a word leaves the FIFO in the same cycle.
  assign issue     = (state_q == S_RUN) &&
                     ((outs_q < CREDITS) || ((outs_q == CREDITS) && hs));
  assign addr_last = (addr_q == LAST_ADDR);
  assign run_last  = issue && addr_last && (vec_q == nv_q - 32'd1);
  assign push      = vld_q[MEM_LAT-1];
  assign out_free  = !tvalid_q || hs;
  assign buf_pull  = out_free && (cnt_q != '0);
  assign buf_push  = push && !(out_free && (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    nv_d    = nv_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    outs_d  = outs_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d    = num_vectors;
          vec_d   = '0;
          addr_d  = '0;
          state_d = (num_vectors == 32'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (run_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hs && (outs_q == OW'(1))) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (issue) begin
      if (addr_last) begin
        addr_d = '0;
        vec_d  = vec_q + 32'd1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    case ({issue, hs})
      2'b10:   outs_d = outs_q + OW'(1);
      2'b01:   outs_d = outs_q - OW'(1);
      default: outs_d = outs_q;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // Tag each issued read so its data is captured exactly MEM_LAT cycles later.
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = issue;
    lst_d[0] = issue && addr_last;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  // Output register is the FIFO head; the buffer only fills while the head is blocked.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    buf_d    = buf_q;
    blst_d   = blst_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;

    if (out_free) begin
      if (cnt_q != '0) begin
        tdata_d  = buf_q[rd_q];
        tlast_d  = blst_q[rd_q];
        tvalid_d = 1'b1;
        rd_d     = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
      end else if (push) begin
        tdata_d  = mem_rdata;
        tlast_d  = lst_q[MEM_LAT-1];
        tvalid_d = 1'b1;
      end else begin
        tvalid_d = 1'b0;
      end
    end

    if (buf_push) begin
      buf_d[wr_q]  = mem_rdata;
      blst_d[wr_q] = lst_q[MEM_LAT-1];
      wr_d         = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
    end

    case ({buf_push, buf_pull})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      nv_q     <= '0;
      vec_q    <= '0;
      addr_q   <= '0;
      outs_q   <= '0;
      vld_q    <= '0;
      lst_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      for (int i = 0; i < BUF_N; i++) begin
        buf_q[i]  <= '0;
        blst_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      nv_q     <= nv_d;
      vec_q    <= vec_d;
      addr_q   <= addr_d;
      outs_q   <= outs_d;
      vld_q    <= vld_d;
      lst_q    <= lst_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      for (int i = 0; i < BUF_N; i++) begin
        buf_q[i]  <= buf_d[i];
        blst_q[i] <= blst_d[i];
      end
    end
  end

  // The credit limit makes both of these unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(buf_push && !buf_pull && (cnt_q == BUF_FULL)));
      assert (outs_q <= CREDITS);
    end
  end

  always_comb begin
    m_axis_weights_tdata         = '0;
    m_axis_weights_tdata[WW-1:0] = tdata_q;
  end

  assign m_axis_weights_tvalid = tvalid_q;
  assign m_axis_weights_tlast  = tlast_q;
  assign mem_en                = issue;
  assign mem_addr              = addr_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule

// File: tb/tb_mvu_weight_sequencer.sv
// Scoreboard bench for mvu_weight_sequencer: a memory model returns data=addr, expected beats
// are queued when a run is started and compared at every AXI handshake.
module tb_mvu_weight_sequencer;

  localparam int MW           = 8;
  localparam int MH           = 4;
  localparam int PE           = 2;
  localparam int SIMD         = 2;
  localparam int WEIGHT_WIDTH = 3;
  localparam int MEM_LAT      = 2;
  localparam int WORDS        = 8;
  localparam int AW           = 3;
  localparam int WW           = 12;
  localparam int WW_BA        = 16;
  localparam int DEPTH        = MEM_LAT + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       num_vectors;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [WW-1:0]     mem_rdata;
  logic [WW_BA-1:0]  tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  int vectors     = 0;
  int miscompares = 0;

  logic [16:0] sb [$];

  int cyc        = 0;
  int beats      = 0;
  int en_count   = 0;
  int v_count    = 0;
  int done_count = 0;
  int first_en   = -1;
  int first_v    = -1;
  int first_beat = -1;
  int last_beat  = -1;
  int done_cyc   = -1;
  int start_cyc  = -1;
  int outs       = 0;
  int max_outs   = 0;

  always #5 clk = ~clk;

  mvu_weight_sequencer #(
    .MW(MW), .MH(MH), .PE(PE), .SIMD(SIMD),
    .WEIGHT_WIDTH(WEIGHT_WIDTH), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_vectors(num_vectors),
    .busy(busy),
    .done(done),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .m_axis_weights_tdata(tdata),
    .m_axis_weights_tvalid(tvalid),
    .m_axis_weights_tready(tready),
    .m_axis_weights_tlast(tlast)
  );

  // Memory model: data equals the address, junk when no read was issued.
  logic [WW-1:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? WW'(mem_addr) : 12'hA5A;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard, hold-stability and outstanding-credit tracking.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin : monitor
    logic [16:0] exp;
    logic        hs;
    cyc++;
    if (rst) begin
      outs       = 0;
      prev_stall = 1'b0;
    end else begin
      hs = tvalid && tready;
      if (start) start_cyc = cyc;
      if (mem_en) begin
        en_count++;
        outs++;
        if (first_en < 0) first_en = cyc;
      end
      if (tvalid) begin
        v_count++;
        if (first_v < 0) first_v = cyc;
      end
      if (prev_stall) begin
        checkOutput("holdValid", 32'(tvalid), 32'd1);
        checkOutput("holdData", 32'(tdata), 32'(prev_data));
        checkOutput("holdLast", 32'(tlast), 32'(prev_last));
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (hs) begin
        beats++;
        outs--;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        if (sb.size() == 0) begin
          checkOutput("extraBeat", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          checkOutput("beatData", 32'(tdata), 32'(exp[15:0]));
          checkOutput("beatLast", 32'(tlast), 32'(exp[16]));
        end
      end
      if (outs > max_outs) max_outs = outs;
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic resetCounters();
    beats = 0; en_count = 0; v_count = 0; done_count = 0;
    first_en = -1; first_v = -1; first_beat = -1; last_beat = -1;
    done_cyc = -1; start_cyc = -1; max_outs = 0;
  endtask

  task automatic applyStimulus(input int nv);
    @(posedge clk); #1;
    start       = 1'b1;
    num_vectors = nv;
    for (int v = 0; v < nv; v++)
      for (int a = 0; a < WORDS; a++)
        sb.push_back({(a == WORDS - 1), 16'(a)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitBeats(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (beats >= n) return;
    end
    checkOutput("beatTimeout", 32'(beats), 32'(n));
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_count > 0) return;
    end
    checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(done), 32'd0);
    checkOutput({tag, "MemEn"}, 32'(mem_en), 32'd0);
    checkOutput({tag, "MemAddr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "Tvalid"}, 32'(tvalid), 32'd0);
    checkOutput({tag, "Tlast"}, 32'(tlast), 32'd0);
    checkOutput({tag, "Tdata"}, 32'(tdata), 32'd0);
  endtask

  initial begin
    int en_snap;
    rst = 1'b1; start = 1'b0; num_vectors = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");

    $display("[TB] test 1: two vectors, tready held high");
    tready = 1'b1;
    resetCounters();
    applyStimulus(2);
    waitDone(200);
    checkOutput("t1Beats", 32'(beats), 32'd16);
    checkOutput("t1FillLat", 32'(first_v - first_en), 32'(MEM_LAT + 1));
    checkOutput("t1BackToBack", 32'(last_beat - first_beat), 32'd15);
    checkOutput("t1DoneLat", 32'(done_cyc - last_beat), 32'd1);
    checkOutput("t1SbEmpty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    checkOutput("t1DonePulses", 32'(done_count), 32'd1);

    $display("[TB] test 2: backpressure after first beat");
    resetCounters();
    applyStimulus(1);
    waitBeats(1, 50);
    tready = 1'b0;
    repeat (5) @(posedge clk);
    en_snap = en_count;
    repeat (5) @(posedge clk);
    checkOutput("t2Stalled", 32'(en_count - en_snap), 32'd0);
    checkOutput("t2PeakOuts", 32'(max_outs), 32'(DEPTH));
    checkOutput("t2OneBeat", 32'(beats), 32'd1);
    #1 tready = 1'b1;
    waitDone(200);
    checkOutput("t2Beats", 32'(beats), 32'd8);
    checkOutput("t2SbEmpty", 32'(sb.size()), 32'd0);

    $display("[TB] test 3: zero vectors");
    resetCounters();
    applyStimulus(0);
    waitDone(20);
    repeat (3) @(posedge clk);
    checkOutput("t3MemEn", 32'(en_count), 32'd0);
    checkOutput("t3Tvalid", 32'(v_count), 32'd0);
    checkOutput("t3DoneLat", 32'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), 32'd1);
    checkOutput("t3DonePulses", 32'(done_count), 32'd1);

    $display("[TB] test 4: start re-pulsed while running");
    resetCounters();
    applyStimulus(1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; num_vectors = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    waitDone(200);
    repeat (20) @(posedge clk);
    checkOutput("t4Beats", 32'(beats), 32'd8);
    checkOutput("t4DonePulses", 32'(done_count), 32'd1);
    checkOutput("t4SbEmpty", 32'(sb.size()), 32'd0);

    $display("[TB] test 5: reset mid-run");
    resetCounters();
    applyStimulus(2);
    waitBeats(5, 100);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("abort");
    resetCounters();
    applyStimulus(1);
    waitDone(200);
    repeat (5) @(posedge clk);
    checkOutput("t5Beats", 32'(beats), 32'd8);
    checkOutput("t5DonePulses", 32'(done_count), 32'd1);
    checkOutput("t5SbEmpty", 32'(sb.size()), 32'd0);

    $display("[TB] test 6: random backpressure");
    resetCounters();
    applyStimulus(3);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      tready = 1'($urandom_range(0, 1));
      if (done_count > 0) break;
    end
    checkOutput("t6Done", 32'(done_count), 32'd1);
    checkOutput("t6Beats", 32'(beats), 32'd24);
    checkOutput("t6MaxOuts", 32'(max_outs <= DEPTH), 32'd1);
    checkOutput("t6SbEmpty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
